pipe_ctrl: RTL and testbench

Pipelined control unit for the 4-stage (ID/EX/MEM/WB) datapath. Decodes the ID-stage opcode into the existing control signal set, then carries those signals through ID/EX, EX/MEM and MEM/WB registers. Also generates load-use stalls, taken-branch flushes and EX operand forwarding selects. Sits between the IF/ID register and the datapath, replacing the combinational decoder; register-address and opcode widths are parametrised.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_decode.sv | 52 +++++
 rtl/pipe_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, forwarding
// select encoding and the per-instruction control bundle.
package pipe_ctrl_pkg;

  // Opcode values as seen in the ID-stage opcode field
  localparam int unsigned OP_ADD = 32'd0;
  localparam int unsigned OP_SUB = 32'd1;
  localparam int unsigned OP_AND = 32'd2;
  localparam int unsigned OP_XOR = 32'd3;
  localparam int unsigned OP_COM = 32'd4;
  localparam int unsigned OP_MUL = 32'd5;
  localparam int unsigned OP_SLL = 32'd6;
  localparam int unsigned OP_SRL = 32'd7;
  localparam int unsigned OP_LW  = 32'd8;
  localparam int unsigned OP_SW  = 32'd9;
  localparam int unsigned OP_BEQ = 32'd10;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_e;

  // Control bundle; aluop is carried beside it because it is the opcode
  // itself and its width follows the module's OPW parameter.
  typedef struct packed {
    logic wen;
    logic alusrc;
    logic branch;
    logic memtoreg;
    logic dmem_read;
    logic dmem_write;
    logic regdst;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decoder: control bundle plus legal / src2-used flags.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] i_op,
  output ctrl_t          o_ctrl,
  output logic           o_legal,
  output logic           o_src2_used
);

  logic [31:0] w_op;
  assign w_op = 32'(i_op);

  // Opcode table; undefined opcodes yield an all-zero bundle and legal=0
  always_comb begin
    o_ctrl      = '0;
    o_legal     = 1'b1;
    o_src2_used = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: begin
        o_ctrl.wen      = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_src2_used     = 1'b1;
      end
      OP_SLL, OP_SRL: begin
        o_ctrl.wen      = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      OP_LW: begin
        o_ctrl.wen       = 1'b1;
        o_ctrl.alusrc    = 1'b1;
        o_ctrl.dmem_read = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.dmem_write = 1'b1;
        o_ctrl.regdst     = 1'b1;
        o_src2_used       = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.regdst = 1'b1;
        o_src2_used   = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, taken-branch flush and EX operand forwarding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 4,
  parameter int unsigned RAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_op,
  input  logic [RAW-1:0] id_src1,
  input  logic [RAW-1:0] id_src2,
  input  logic [RAW-1:0] id_dst,
  input  logic           ex_zero,
  output logic           stall,
  output logic           flush,
  output logic [OPW-1:0] ex_aluop,
  output logic           ex_alusrc,
  output logic           ex_regdst,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b,
  output logic           mem_dmem_read,
  output logic           mem_dmem_write,
  output logic           wb_wen,
  output logic           wb_memtoreg,
  output logic [RAW-1:0] wb_dst,
  output logic           illegal
);

  ctrl_t          w_id_ctrl;
  logic           w_id_legal;
  logic           w_id_src2_used;

  // ID/EX register
  logic           r_ex_valid;
  ctrl_t          r_ex_ctrl;
  logic [OPW-1:0] r_ex_aluop;
  logic [RAW-1:0] r_ex_dst;
  logic [RAW-1:0] r_ex_src1;
  logic [RAW-1:0] r_ex_src2;

  // EX/MEM register (only the fields still needed downstream)
  logic           r_mem_valid;
  logic           r_mem_wen;
  logic           r_mem_memtoreg;
  logic           r_mem_dmem_read;
  logic           r_mem_dmem_write;
  logic [RAW-1:0] r_mem_dst;

  // MEM/WB register
  logic           r_wb_valid;
  logic           r_wb_wen;
  logic           r_wb_memtoreg;
  logic [RAW-1:0] r_wb_dst;

  logic           r_illegal;

  logic           w_ex_load;
  logic           w_src_hit;
  logic           w_stall;
  logic           w_flush;
  logic           w_bubble;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .i_op        (id_op),
    .o_ctrl      (w_id_ctrl),
    .o_legal     (w_id_legal),
    .o_src2_used (w_id_src2_used)
  );

  // Hazard detection; flush wins over stall
  assign w_ex_load = r_ex_valid & r_ex_ctrl.dmem_read;
  assign w_src_hit = (r_ex_dst == id_src1) |
                     (w_id_src2_used & (r_ex_dst == id_src2));
  assign w_flush   = r_ex_valid & r_ex_ctrl.branch & ex_zero;
  assign w_stall   = w_ex_load & id_valid & w_id_legal & w_src_hit & ~w_flush;
  assign w_bubble  = ~id_valid | ~w_id_legal | w_stall | w_flush;

  assign stall = w_stall;
  assign flush = w_flush;

  // Forward select for EX src1; a load in EX/MEM (memtoreg=0) never forwards
  always_comb begin
    fwd_a = FWD_RF;
    if (r_ex_valid) begin
      if (r_mem_valid & r_mem_wen & r_mem_memtoreg & (r_mem_dst == r_ex_src1))
        fwd_a = FWD_MEM;
      else if (r_wb_valid & r_wb_wen & (r_wb_dst == r_ex_src1))
        fwd_a = FWD_WB;
    end
  end

  // Forward select for EX src2, same rules as src1
  always_comb begin
    fwd_b = FWD_RF;
    if (r_ex_valid) begin
      if (r_mem_valid & r_mem_wen & r_mem_memtoreg & (r_mem_dst == r_ex_src2))
        fwd_b = FWD_MEM;
      else if (r_wb_valid & r_wb_wen & (r_wb_dst == r_ex_src2))
        fwd_b = FWD_WB;
    end
  end

  // ID/EX: load decoded instruction, or a fully zeroed bubble
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_aluop <= '0;
      r_ex_dst   <= '0;
      r_ex_src1  <= '0;
      r_ex_src2  <= '0;
    end else begin
      r_ex_valid <= 1'b1;
      r_ex_ctrl  <= w_id_ctrl;
      r_ex_aluop <= id_op;
      r_ex_dst   <= id_dst;
      r_ex_src1  <= id_src1;
      r_ex_src2  <= id_src2;
    end
  end

  // EX/MEM: always advances
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_valid      <= 1'b0;
      r_mem_wen        <= 1'b0;
      r_mem_memtoreg   <= 1'b0;
      r_mem_dmem_read  <= 1'b0;
      r_mem_dmem_write <= 1'b0;
      r_mem_dst        <= '0;
    end else begin
      r_mem_valid      <= r_ex_valid;
      r_mem_wen        <= r_ex_ctrl.wen;
      r_mem_memtoreg   <= r_ex_ctrl.memtoreg;
      r_mem_dmem_read  <= r_ex_ctrl.dmem_read;
      r_mem_dmem_write <= r_ex_ctrl.dmem_write;
      r_mem_dst        <= r_ex_dst;
    end
  end

  // MEM/WB: always advances
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid    <= 1'b0;
      r_wb_wen      <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_dst      <= '0;
    end else begin
      r_wb_valid    <= r_mem_valid;
      r_wb_wen      <= r_mem_wen;
      r_wb_memtoreg <= r_mem_memtoreg;
      r_wb_dst      <= r_mem_dst;
    end
  end

  // Sticky flag for any undefined opcode presented in ID
  always_ff @(posedge clk) begin
    if (rst) r_illegal <= 1'b0;
    else     r_illegal <= r_illegal | (id_valid & ~w_id_legal);
  end

  // Bubbles carry zero controls, so stage outputs come straight from the registers
  assign ex_aluop       = r_ex_aluop;
  assign ex_alusrc      = r_ex_ctrl.alusrc;
  assign ex_regdst      = r_ex_ctrl.regdst;
  assign mem_dmem_read  = r_mem_dmem_read;
  assign mem_dmem_write = r_mem_dmem_write;
  assign wb_wen         = r_wb_wen;
  assign wb_memtoreg    = r_wb_memtoreg;
  assign wb_dst         = r_wb_dst;
  assign illegal        = r_illegal;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process acts as the datapath
// and pushes the model's expected outputs; a negedge monitor compares them.
module tb_pipe_ctrl;

  localparam int ADD = 0, SUB = 1, AND_ = 2, XOR_ = 3, COM = 4, MUL = 5;
  localparam int SLL = 6, SRL = 7, LW = 8, SW = 9, BEQ = 10;
  localparam int NRAND = 600;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_op, id_src1, id_src2, id_dst;
  logic       ex_zero;
  logic       stall, flush;
  logic [3:0] ex_aluop;
  logic       ex_alusrc, ex_regdst;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_dmem_read, mem_dmem_write;
  logic       wb_wen, wb_memtoreg;
  logic [3:0] wb_dst;
  logic       illegal;

  always #5 clk = ~clk;

  pipe_ctrl #(.OPW(4), .RAW(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst), .ex_zero(ex_zero),
    .stall(stall), .flush(flush), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .ex_regdst(ex_regdst), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_dmem_read(mem_dmem_read), .mem_dmem_write(mem_dmem_write),
    .wb_wen(wb_wen), .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst),
    .illegal(illegal)
  );

  // One instruction as the datapath sees it; z/r are the ex_zero and rst
  // values driven while this instruction sits in ID.
  typedef struct {
    bit v;
    int op, s1, s2, d;
    bit z, r;
  } ins_t;

  typedef struct packed {
    logic       stall, flush;
    logic [3:0] aluop;
    logic       alusrc, regdst;
    logic [1:0] fa, fb;
    logic       mrd, mwr, wwen, wm2r;
    logic [3:0] wdst;
    logic       ill;
  } exp_t;

  exp_t q[$];
  ins_t dir[$];
  ins_t m_ex, m_mem, m_wb, bub, cur;
  bit   m_ill;
  int   checks = 0;
  int   errors = 0;

  // Reference rules straight from the opcode table
  function automatic bit f_legal(int op);  return op >= ADD && op <= BEQ; endfunction
  function automatic bit f_wen(int op);    return op >= ADD && op <= LW; endfunction
  function automatic bit f_aluwb(int op);  return op >= ADD && op <= SRL; endfunction
  function automatic bit f_alusrc(int op); return op == SLL || op == SRL || op == LW || op == SW; endfunction
  function automatic bit f_regdst(int op); return op == SW || op == BEQ; endfunction
  function automatic bit f_uses2(int op);
    return (op >= ADD && op <= MUL) || op == SW || op == BEQ;
  endfunction

  function automatic int f_fwd(int r);
    if (m_mem.v && f_wen(m_mem.op) && f_aluwb(m_mem.op) && m_mem.d == r) return 1;
    if (m_wb.v && f_wen(m_wb.op) && m_wb.d == r) return 2;
    return 0;
  endfunction

  function automatic ins_t mk(bit v, int op, int s1, int s2, int d, bit z, bit r);
    ins_t t;
    t.v = v; t.op = op; t.s1 = s1; t.s2 = s2; t.d = d; t.z = z; t.r = r;
    return t;
  endfunction

  function automatic ins_t next_instr();
    ins_t t;
    if (dir.size() > 0) return dir.pop_front();
    t.v  = ($urandom_range(0, 9) != 0);
    t.op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
    t.s1 = int'($urandom_range(0, 3));
    t.s2 = int'($urandom_range(0, 3));
    t.d  = int'($urandom_range(0, 3));
    t.z  = bit'($urandom_range(0, 1));
    t.r  = ($urandom_range(0, 99) == 0);
    return t;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      chk("flush", int'(flush), int'(e.flush));
      chk("ex_ctrl", int'({ex_aluop, ex_alusrc, ex_regdst}), int'({e.aluop, e.alusrc, e.regdst}));
      chk("fwd_a", int'(fwd_a), int'(e.fa));
      chk("fwd_b", int'(fwd_b), int'(e.fb));
      chk("mem_ctrl", int'({mem_dmem_read, mem_dmem_write}), int'({e.mrd, e.mwr}));
      chk("wb_ctrl", int'({wb_wen, wb_memtoreg, wb_dst}), int'({e.wwen, e.wm2r, e.wdst}));
      chk("illegal", int'(illegal), int'(e.ill));
    end
  end

  initial begin
    exp_t e;
    bit   s, f;
    bub = mk(0, 0, 0, 0, 0, 0, 0);

    // Reset and single instruction: ADD r1,r2 -> r3, then idle
    dir.push_back(mk(1, ADD, 1, 2, 3, 0, 0));
    repeat (3) dir.push_back(bub);
    // EX/MEM forwarding, then MEM/WB forwarding across an independent op
    dir.push_back(mk(1, ADD, 2, 3, 1, 0, 0));
    dir.push_back(mk(1, SUB, 1, 1, 2, 0, 0));
    dir.push_back(mk(1, ADD, 2, 3, 1, 0, 0));
    dir.push_back(mk(1, XOR_, 4, 6, 7, 0, 0));
    dir.push_back(mk(1, SUB, 1, 1, 2, 0, 0));
    dir.push_back(bub); dir.push_back(bub);
    // Load-use stall, then load followed by an SLL that only shares src2
    dir.push_back(mk(1, LW, 0, 0, 5, 0, 0));
    dir.push_back(mk(1, ADD, 5, 6, 7, 0, 0));
    dir.push_back(bub); dir.push_back(bub);
    dir.push_back(mk(1, LW, 0, 0, 5, 0, 0));
    dir.push_back(mk(1, SLL, 2, 5, 8, 0, 0));
    dir.push_back(bub); dir.push_back(bub);
    // Taken branch flushes the next ID instruction; untaken branch does not
    dir.push_back(mk(1, BEQ, 1, 2, 0, 0, 0));
    dir.push_back(mk(1, ADD, 3, 4, 9, 1, 0));
    dir.push_back(mk(1, ADD, 3, 4, 10, 0, 0));
    dir.push_back(mk(1, BEQ, 1, 2, 0, 0, 0));
    dir.push_back(mk(1, ADD, 3, 4, 9, 0, 0));
    // Illegal opcode, sticky across valid instructions
    dir.push_back(mk(1, 15, 1, 2, 3, 0, 0));
    dir.push_back(mk(1, MUL, 1, 2, 3, 0, 0));
    dir.push_back(mk(1, SW, 3, 1, 0, 0, 0));
    // Reset with the LW in MEM
    dir.push_back(mk(1, LW, 1, 0, 10, 0, 0));
    dir.push_back(mk(1, ADD, 1, 2, 11, 0, 0));
    dir.push_back(mk(1, ADD, 2, 3, 12, 0, 1));
    dir.push_back(mk(1, COM, 1, 1, 4, 0, 0));

    rst = 1'b1; id_valid = 1'b0; id_op = '0; id_src1 = '0; id_src2 = '0;
    id_dst = '0; ex_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_ex = bub; m_mem = bub; m_wb = bub; m_ill = 1'b0;
    cur = next_instr();

    for (int c = 0; c < NRAND + 40; c++) begin
      rst      = cur.r;
      id_valid = cur.v;
      id_op    = 4'(cur.op);
      id_src1  = 4'(cur.s1);
      id_src2  = 4'(cur.s2);
      id_dst   = 4'(cur.d);
      ex_zero  = cur.z;

      f = m_ex.v && m_ex.op == BEQ && cur.z;
      s = !f && m_ex.v && m_ex.op == LW && cur.v && f_legal(cur.op) &&
          (m_ex.d == cur.s1 || (f_uses2(cur.op) && m_ex.d == cur.s2));
      e = '0;
      e.stall  = s;
      e.flush  = f;
      e.aluop  = m_ex.v ? 4'(m_ex.op) : 4'd0;
      e.alusrc = m_ex.v && f_alusrc(m_ex.op);
      e.regdst = m_ex.v && f_regdst(m_ex.op);
      e.fa     = m_ex.v ? 2'(f_fwd(m_ex.s1)) : 2'd0;
      e.fb     = m_ex.v ? 2'(f_fwd(m_ex.s2)) : 2'd0;
      e.mrd    = m_mem.v && m_mem.op == LW;
      e.mwr    = m_mem.v && m_mem.op == SW;
      e.wwen   = m_wb.v && f_wen(m_wb.op);
      e.wm2r   = m_wb.v && f_aluwb(m_wb.op);
      e.wdst   = m_wb.v ? 4'(m_wb.d) : 4'd0;
      e.ill    = m_ill;
      q.push_back(e);

      @(posedge clk);
      #1;
      if (cur.r) begin
        m_ex = bub; m_mem = bub; m_wb = bub; m_ill = 1'b0;
      end else begin
        m_ill = m_ill || (cur.v && !f_legal(cur.op));
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (cur.v && f_legal(cur.op) && !s && !f) ? cur : bub;
      end
      // A stalled instruction stays in IF/ID; otherwise fetch the next one
      if (!s || cur.r) cur = next_instr();
    end

    rst = 1'b0; id_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
